cpu_debug_ocimem_seq: RTL and testbench
=======================================

CPU_DEBUG_OCIMEM_SEQ -- requirements
Module: cpu_debug_ocimem_seq

Interface
REQ-001 Parameters SHALL be: ADDR_W, 8, word-address width of on-chip debug memory.
REQ-002 Parameters SHALL continue: TIMEOUT, 16, maximum waitrequest cycles before abort (range 2..255).
REQ-003 There SHALL be one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  system clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 take_action_ocimem_a  input  1  one-cycle strobe: load address; start read if jdo[34]=1.
REQ-007 take_action_ocimem_b  input  1  one-cycle strobe: write jdo[34:3] at current address.
REQ-008 take_no_action_ocimem_a  input  1  one-cycle strobe: read at current address.
REQ-009 jdo  input  38  debug data word; address field jdo[ADDR_W+9:10].
REQ-010 mem_readdata  input  32  debug memory read data.
REQ-011 mem_waitrequest  input  1  debug memory stall; access completes on a cycle it is low.
REQ-012 mem_address  output  ADDR_W  current word address.
REQ-013 mem_read, mem_write  output  1 each  access strobes, held until completion.
REQ-014 mem_writedata  output  32  write data, stable while mem_write high.
REQ-015 MonDReg  output  32  last read data returned to the debugger.
REQ-016 monitor_ready  output  1  high once the last command has finished.
REQ-017 monitor_error  output  1  sticky error flag (timeout or overrun).
REQ-018 busy  output  1  high in READ or WRITE state.

Function
REQ-019 The FSM SHALL have states IDLE, READ and WRITE; busy=1 exactly when the state is not IDLE.
REQ-020 In IDLE, if more than one strobe is high, priority SHALL be ocimem_a > ocimem_b > no_action_ocimem_a; lower-priority strobes are dropped without error.
REQ-021 On ocimem_a, mem_address SHALL load from jdo and monitor_ready SHALL clear.
REQ-022 On ocimem_a, the FSM SHALL go to READ if jdo[34]=1; otherwise it SHALL stay in IDLE and set monitor_ready the next cycle.
REQ-023 On ocimem_b, mem_writedata SHALL load jdo[34:3], monitor_ready SHALL clear, and the FSM SHALL go to WRITE.
REQ-024 On no_action_ocimem_a, monitor_ready SHALL clear and the FSM SHALL go to READ.
REQ-025 mem_read SHALL be high for every cycle in READ, and mem_write SHALL be high for every cycle in WRITE; both SHALL never be high together.
REQ-026 Latency: a strobe in cycle N SHALL raise the access strobe in N+1.
REQ-027 With waitrequest low in N+1, the access SHALL complete in N+1, and MonDReg (reads) and monitor_ready SHALL be valid in N+2.
REQ-028 Completion SHALL occur on the first READ/WRITE cycle with mem_waitrequest=0.
REQ-029 On completion, a read SHALL capture mem_readdata into MonDReg.
REQ-030 On completion, mem_address SHALL increment by 1 modulo 2^ADDR_W (all-ones wraps to 0).
REQ-031 On completion, monitor_ready SHALL set and the FSM SHALL return to IDLE.
REQ-032 A wait counter SHALL clear on entry to READ/WRITE and SHALL increment each stalled cycle.
REQ-033 If TIMEOUT consecutive cycles stall, the access SHALL abort: strobe deasserted, address unchanged, MonDReg unchanged, monitor_error=1, monitor_ready=1, return to IDLE.
REQ-034 Any strobe arriving while busy SHALL be ignored and SHALL set monitor_error (overrun); the in-flight access SHALL continue unaffected.
REQ-035 monitor_error SHALL clear only when ocimem_a is accepted with jdo[33]=1; otherwise it is sticky.
REQ-036 The clear of REQ-035 and an overrun or timeout in the same cycle SHALL leave monitor_error set.
REQ-037 mem_writedata SHALL hold its value until the next accepted ocimem_b.

Reset
REQ-038 While reset=1, state SHALL be IDLE and mem_address, mem_read, mem_write, mem_writedata, MonDReg, monitor_error, busy and the wait counter SHALL all be 0.
REQ-039 While reset=1, monitor_ready SHALL be 1.
REQ-040 Reset asserted mid-access SHALL drop mem_read/mem_write in the next cycle with no completion side effects.
REQ-041 Strobes coincident with reset SHALL be discarded.

Verification
REQ-042 Bench SHALL cover: ocimem_a, jdo address=0x10, jdo[34]=1, waitrequest low, readdata=0xDEADBEEF -> mem_read in N+1 only; MonDReg=0xDEADBEEF and mem_address=0x11 in N+2; monitor_ready=1.
REQ-043 Bench SHALL cover: ocimem_b, data 0x12345678, waitrequest high 3 cycles -> mem_write high 4 cycles with writedata 0x12345678; address +1; monitor_error stays 0.
REQ-044 Bench SHALL cover: address 0xFF, no_action_ocimem_a -> read at 0xFF, then mem_address=0x00.
REQ-045 Bench SHALL cover: waitrequest stuck high, TIMEOUT=16 -> mem_read high exactly 16 cycles; monitor_error=1, monitor_ready=1; address unchanged.
REQ-046 Bench SHALL cover: ocimem_b while in READ, then ocimem_a with jdo[33]=1 -> monitor_error set by the overrun; the read completes normally; the error clears after the ocimem_a.
REQ-047 Bench SHALL cover: reset in the 2nd stalled cycle of a write -> mem_write=0 next cycle; all outputs at reset values; address 0.

Source files
------------

// File: rtl/cpu_debug_ocimem_seq_if.sv
// Debug-memory bus between the OCI memory sequencer (master) and the on-chip
// debug RAM (slave).
interface cpu_debug_ocimem_seq_if #(
  parameter int unsigned ADDR_W = 8
);
  logic [ADDR_W-1:0] mem_address;
  logic              mem_read;
  logic              mem_write;
  logic [31:0]       mem_writedata;
  logic [31:0]       mem_readdata;
  logic              mem_waitrequest;

  modport master (
    output mem_address,
    output mem_read,
    output mem_write,
    output mem_writedata,
    input  mem_readdata,
    input  mem_waitrequest
  );

  modport slave (
    input  mem_address,
    input  mem_read,
    input  mem_write,
    input  mem_writedata,
    output mem_readdata,
    output mem_waitrequest
  );
endinterface

// File: rtl/cpu_debug_ocimem_seq.sv
// JTAG debug sequencer for the OCI debug memory: turns debugger strobes into
// single-word read/write accesses with auto-increment, timeout and overrun flags.
module cpu_debug_ocimem_seq #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        take_action_ocimem_a_i,
  input  logic        take_action_ocimem_b_i,
  input  logic        take_no_action_ocimem_a_i,
  input  logic [37:0] jdo_i,
  cpu_debug_ocimem_seq_if.master mem,
  output logic [31:0] mon_dreg_o,
  output logic        monitor_ready_o,
  output logic        monitor_error_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {StIdle, StRead, StWrite} state_e;

  localparam logic [ADDR_W-1:0] AddrOne = ADDR_W'(1);
  localparam logic [7:0]        WaitMax = 8'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       dreg_q, dreg_d;
  logic [7:0]        wait_q, wait_d;
  logic              ready_q, ready_d;
  logic              err_q, err_d;

  logic idle, in_access, any_strobe, stall, done, timeout;
  logic accept_a, accept_b, accept_n;
  logic unused_jdo;

  assign unused_jdo = ^{jdo_i[37:35], jdo_i[2:0]};

  assign idle       = (state_q == StIdle);
  assign in_access  = ~idle;
  assign any_strobe = take_action_ocimem_a_i | take_action_ocimem_b_i |
                      take_no_action_ocimem_a_i;
  assign stall      = in_access & mem.mem_waitrequest;
  assign done       = in_access & ~mem.mem_waitrequest;
  assign timeout    = stall & (wait_q == WaitMax);

  // Strobe priority only matters in IDLE; while busy every strobe is an overrun.
  assign accept_a = idle & take_action_ocimem_a_i;
  assign accept_b = idle & ~take_action_ocimem_a_i & take_action_ocimem_b_i;
  assign accept_n = idle & ~take_action_ocimem_a_i & ~take_action_ocimem_b_i &
                    take_no_action_ocimem_a_i;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      addr_q  <= '0;
      wdata_q <= '0;
      dreg_q  <= '0;
      wait_q  <= '0;
      ready_q <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      dreg_q  <= dreg_d;
      wait_q  <= wait_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (take_action_ocimem_a_i) begin
          state_d = jdo_i[34] ? StRead : StIdle;
        end else if (take_action_ocimem_b_i) begin
          state_d = StWrite;
        end else if (take_no_action_ocimem_a_i) begin
          state_d = StRead;
        end
      end
      StRead, StWrite: begin
        if (done || timeout) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    dreg_d  = dreg_q;
    wait_d  = '0;
    ready_d = ready_q;
    err_d   = err_q;

    if (accept_a) begin
      addr_d = jdo_i[ADDR_W+9:10];
    end
    if (accept_b) begin
      wdata_d = jdo_i[34:3];
    end
    if (done) begin
      addr_d = addr_q + AddrOne;
      if (state_q == StRead) begin
        dreg_d = mem.mem_readdata;
      end
    end
    if (stall && !timeout) begin
      wait_d = wait_q + 8'd1;
    end

    // Idle without a new command always reports ready; a finished access does too.
    if (idle) begin
      ready_d = ~(accept_a | accept_b | accept_n);
    end else begin
      ready_d = done | timeout;
    end

    // Set wins over clear so a same-cycle error is never lost.
    if (accept_a && jdo_i[33]) begin
      err_d = 1'b0;
    end
    if ((in_access && any_strobe) || timeout) begin
      err_d = 1'b1;
    end
  end

  always_comb begin
    busy_o            = in_access;
    mem.mem_read      = (state_q == StRead);
    mem.mem_write     = (state_q == StWrite);
    mem.mem_address   = addr_q;
    mem.mem_writedata = wdata_q;
    mon_dreg_o        = dreg_q;
    monitor_ready_o   = ready_q;
    monitor_error_o   = err_q;
  end

endmodule

// File: tb/tb_cpu_debug_ocimem_seq.sv
// Bench for cpu_debug_ocimem_seq: a transaction-level model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_cpu_debug_ocimem_seq;
  localparam int unsigned AW = 8;
  localparam int unsigned TO = 16;

  logic        clk;
  logic        reset;
  logic        take_a, take_b, take_n;
  logic [37:0] jdo;
  logic [31:0] mon_dreg;
  logic        mon_ready, mon_error, busy;

  cpu_debug_ocimem_seq_if #(.ADDR_W(AW)) mem_if ();

  cpu_debug_ocimem_seq #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk                       (clk),
    .reset                     (reset),
    .take_action_ocimem_a_i    (take_a),
    .take_action_ocimem_b_i    (take_b),
    .take_no_action_ocimem_a_i (take_n),
    .jdo_i                     (jdo),
    .mem                       (mem_if),
    .mon_dreg_o                (mon_dreg),
    .monitor_ready_o           (mon_ready),
    .monitor_error_o           (mon_error),
    .busy_o                    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: an access is "in flight" of some kind with a stall tally; outputs follow.
  int          m_kind;  // 0 none, 1 read, 2 write
  int          m_stalls;
  logic [7:0]  m_addr;
  logic [31:0] m_wdata, m_dreg;
  bit          m_ready, m_err, m_valid;

  initial m_valid = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_kind = 0; m_stalls = 0; m_addr = 0; m_wdata = 0; m_dreg = 0;
      m_ready = 1; m_err = 0; m_valid = 1;
    end else if (m_valid) begin
      if (m_kind != 0) begin
        if (take_a || take_b || take_n) m_err = 1;
        if (!mem_if.mem_waitrequest) begin
          if (m_kind == 1) m_dreg = mem_if.mem_readdata;
          m_addr  = m_addr + 8'd1;
          m_ready = 1;
          m_kind  = 0;
        end else begin
          m_stalls++;
          if (m_stalls == TO) begin
            m_err = 1; m_ready = 1; m_kind = 0;
          end
        end
      end else if (take_a) begin
        m_addr  = jdo[17:10];
        m_ready = 0;
        if (jdo[33]) m_err = 0;
        m_kind = jdo[34] ? 1 : 0;
        m_stalls = 0;
      end else if (take_b) begin
        m_wdata = jdo[34:3]; m_ready = 0; m_kind = 2; m_stalls = 0;
      end else if (take_n) begin
        m_ready = 0; m_kind = 1; m_stalls = 0;
      end else begin
        m_ready = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("busy", {31'b0, busy}, {31'b0, m_kind != 0});
      check("mem_read", {31'b0, mem_if.mem_read}, {31'b0, m_kind == 1});
      check("mem_write", {31'b0, mem_if.mem_write}, {31'b0, m_kind == 2});
      check("rd_wr_excl", {31'b0, mem_if.mem_read & mem_if.mem_write}, 32'd0);
      check("mem_address", {24'b0, mem_if.mem_address}, {24'b0, m_addr});
      check("mem_writedata", mem_if.mem_writedata, m_wdata);
      check("MonDReg", mon_dreg, m_dreg);
      check("monitor_ready", {31'b0, mon_ready}, {31'b0, m_ready});
      check("monitor_error", {31'b0, mon_error}, {31'b0, m_err});
    end
    if (mem_if.mem_read)  rd_cnt++;
    if (mem_if.mem_write) wr_cnt++;
  end

  function automatic logic [37:0] rjdo(input logic [7:0] addr, input bit rd, input bit clr);
    return {3'b0, rd, clr, 15'b0, addr, 10'b0};
  endfunction

  function automatic logic [37:0] wjdo(input logic [31:0] data);
    return {3'b0, data, 3'b0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Strobe for exactly one cycle; returns one step into the following cycle.
  task automatic pulse(input bit a, input bit b, input bit n, input logic [37:0] j);
    take_a = a; take_b = b; take_n = n; jdo = j;
    tick();
    take_a = 0; take_b = 0; take_n = 0;
  endtask

  task automatic wait_idle(input string name, input int max_cycles);
    int n = 0;
    while (busy !== 1'b0 && n < max_cycles) begin
      tick();
      n++;
    end
    check({name, "_idle_bound"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    reset = 1; take_a = 0; take_b = 0; take_n = 0; jdo = '0;
    mem_if.mem_readdata = '0; mem_if.mem_waitrequest = 1'b0;
    tick(); tick();
    // Strobe coincident with reset must be discarded.
    pulse(1, 0, 0, rjdo(8'h55, 1, 0));
    tick();
    reset = 0;
    check("rst_ready", {31'b0, mon_ready}, 32'd1);
    check("rst_addr", {24'b0, mem_if.mem_address}, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_error", {31'b0, mon_error}, 32'd0);
    tick();

    // Zero-wait read at 0x10.
    mem_if.mem_readdata = 32'hDEADBEEF;
    rd_cnt = 0;
    pulse(1, 0, 0, rjdo(8'h10, 1, 0));
    check("rd_n1_read", {31'b0, mem_if.mem_read}, 32'd1);
    check("rd_n1_addr", {24'b0, mem_if.mem_address}, 32'h10);
    tick();
    check("rd_n2_read", {31'b0, mem_if.mem_read}, 32'd0);
    check("rd_n2_dreg", mon_dreg, 32'hDEADBEEF);
    check("rd_n2_addr", {24'b0, mem_if.mem_address}, 32'h11);
    check("rd_n2_ready", {31'b0, mon_ready}, 32'd1);
    check("rd_cycles", rd_cnt, 32'd1);

    // Write with three stall cycles.
    mem_if.mem_waitrequest = 1'b1;
    wr_cnt = 0;
    pulse(0, 1, 0, wjdo(32'h12345678));
    check("wr_n1_write", {31'b0, mem_if.mem_write}, 32'd1);
    check("wr_n1_data", mem_if.mem_writedata, 32'h12345678);
    tick(); tick(); tick();
    mem_if.mem_waitrequest = 1'b0;
    wait_idle("wr", 10);
    check("wr_cycles", wr_cnt, 32'd4);
    check("wr_addr", {24'b0, mem_if.mem_address}, 32'h12);
    check("wr_error", {31'b0, mon_error}, 32'd0);

    // Address load without read, then read at 0xFF wrapping to 0.
    pulse(1, 0, 0, rjdo(8'hFF, 0, 0));
    check("ld_busy", {31'b0, busy}, 32'd0);
    check("ld_ready_low", {31'b0, mon_ready}, 32'd0);
    tick();
    check("ld_ready_high", {31'b0, mon_ready}, 32'd1);
    mem_if.mem_readdata = 32'hCAFEF00D;
    pulse(0, 0, 1, '0);
    check("wrap_addr_ff", {24'b0, mem_if.mem_address}, 32'hFF);
    tick();
    check("wrap_addr_00", {24'b0, mem_if.mem_address}, 32'h00);
    check("wrap_dreg", mon_dreg, 32'hCAFEF00D);

    // Stuck waitrequest: abort after exactly TIMEOUT read cycles.
    mem_if.mem_waitrequest = 1'b1;
    rd_cnt = 0;
    pulse(0, 0, 1, '0);
    wait_idle("to", 40);
    check("to_cycles", rd_cnt, 32'd16);
    check("to_error", {31'b0, mon_error}, 32'd1);
    check("to_ready", {31'b0, mon_ready}, 32'd1);
    check("to_addr", {24'b0, mem_if.mem_address}, 32'h00);
    check("to_dreg", mon_dreg, 32'hCAFEF00D);
    mem_if.mem_waitrequest = 1'b0;
    pulse(1, 0, 0, rjdo(8'h20, 0, 1));
    check("clr_error", {31'b0, mon_error}, 32'd0);
    tick();

    // Overrun during a stalled read; the read still completes.
    mem_if.mem_waitrequest = 1'b1;
    pulse(0, 0, 1, '0);
    pulse(0, 1, 0, wjdo(32'h77777777));
    check("ovr_error", {31'b0, mon_error}, 32'd1);
    check("ovr_still_read", {31'b0, mem_if.mem_read}, 32'd1);
    check("ovr_no_write", {31'b0, mem_if.mem_write}, 32'd0);
    mem_if.mem_readdata = 32'h0BADF00D;
    mem_if.mem_waitrequest = 1'b0;
    tick();
    check("ovr_dreg", mon_dreg, 32'h0BADF00D);
    check("ovr_addr", {24'b0, mem_if.mem_address}, 32'h21);
    check("ovr_wdata_kept", mem_if.mem_writedata, 32'h12345678);
    pulse(1, 0, 0, rjdo(8'h21, 0, 1));
    check("ovr_cleared", {31'b0, mon_error}, 32'd0);
    tick();

    // Reset in the second stalled cycle of a write.
    mem_if.mem_waitrequest = 1'b1;
    pulse(0, 1, 0, wjdo(32'hA5A5A5A5));
    tick();
    reset = 1;
    tick();
    reset = 0;
    mem_if.mem_waitrequest = 1'b0;
    check("rstw_write", {31'b0, mem_if.mem_write}, 32'd0);
    check("rstw_addr", {24'b0, mem_if.mem_address}, 32'h0);
    check("rstw_wdata", mem_if.mem_writedata, 32'h0);
    check("rstw_ready", {31'b0, mon_ready}, 32'd1);
    tick();

    // All strobes together: ocimem_a wins, no error.
    pulse(1, 1, 1, rjdo(8'h33, 0, 0));
    check("prio_busy", {31'b0, busy}, 32'd0);
    check("prio_addr", {24'b0, mem_if.mem_address}, 32'h33);
    check("prio_error", {31'b0, mon_error}, 32'd0);
    mem_if.mem_readdata = 32'h11112222;
    pulse(1, 1, 1, rjdo(8'h40, 1, 0));
    check("prio_read", {31'b0, mem_if.mem_read}, 32'd1);
    wait_idle("prio", 5);
    check("prio_dreg", mon_dreg, 32'h11112222);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    fails++;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
